// File: rtl/busreq_arbiter.sv
// Z80 bus-mastership arbiter for two secondary bus masters.
//
// Runs the BUSRQ/BUSACK handshake, grants the bus to one requester at a time
// (round-robin when both are eligible), cuts a tenure off after HOLD_MAX
// cycles and then leaves the bus with the CPU for CPU_MIN cycles.
//
// Ports:
//   clk_i      system clock (undivided oscillator clock)
//   rst_ni     asynchronous active-low reset
//   busack_ni  active-low BUSACK from the Z80, asynchronous to clk_i
//   req_i      active-high requests, bit 0 = requester 0, bit 1 = requester 1
//   busrq_no   active-low BUSRQ to the Z80
//   grant_o    one-hot grant, at most one bit set
//   bus_en_o   enable for the granted requester's drivers
//   timeout_o  one-cycle pulse when a tenure is cut off at HOLD_MAX
module busreq_arbiter #(
  parameter int unsigned HOLD_MAX = 64,  // 1..255
  parameter int unsigned CPU_MIN  = 8    // 0..255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       busack_ni,
  input  logic [1:0] req_i,
  output logic       busrq_no,
  output logic [1:0] grant_o,
  output logic       bus_en_o,
  output logic       timeout_o
);

  localparam logic [7:0] HoldMax = 8'(HOLD_MAX);
  localparam logic [7:0] CpuMin  = 8'(CPU_MIN);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StGrant,
    StRelease,
    StCool
  } state_e;

  state_e      state_q, state_d;
  logic        ack_meta_q, ack_s_q;
  logic        winner_q, winner_d;
  logic        last_q, last_d;
  logic [1:0]  blocked_q, blocked_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  cool_q, cool_d;
  logic        busrq_q, busrq_d;
  logic [1:0]  grant_q, grant_d;
  logic        bus_en_q, bus_en_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  eligible;

  assign eligible = req_i & ~blocked_q;

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    cool_d    = cool_q;
    timeout_d = 1'b0;
    // A blocked requester is forgiven as soon as it lets go of req.
    blocked_d = blocked_q & req_i;

    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d  = StReq;
          // Both eligible: serve the one that was not granted last time.
          winner_d = (&eligible) ? ~last_q : eligible[1];
        end
      end
      StReq: begin
        if (!req_i[winner_q]) begin
          state_d = StRelease;
        end else if (!ack_s_q) begin
          state_d = StGrant;
          last_d  = winner_q;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
        if (!req_i[winner_q]) begin
          state_d = StRelease;
        end else if (({1'b0, hold_q} + 9'd1) >= {1'b0, HoldMax}) begin
          state_d             = StRelease;
          timeout_d           = 1'b1;
          blocked_d[winner_q] = 1'b1;
        end else if (ack_s_q) begin
          // CPU took the bus back on its own; give up rather than hang.
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (ack_s_q) begin
          if (CpuMin == 8'd0) begin
            state_d = StIdle;
          end else begin
            state_d = StCool;
            cool_d  = CpuMin;
          end
        end
      end
      StCool: begin
        if (cool_q > 8'd1) begin
          cool_d = cool_q - 8'd1;
        end else begin
          cool_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state and registered.
    busrq_d  = !((state_d == StReq) || (state_d == StGrant));
    bus_en_d = (state_d == StGrant);
    grant_d  = (state_d == StGrant) ? (winner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ack_meta_q <= 1'b1;
      ack_s_q    <= 1'b1;
      winner_q   <= 1'b0;
      last_q     <= 1'b1;
      blocked_q  <= 2'b00;
      hold_q     <= '0;
      cool_q     <= '0;
      busrq_q    <= 1'b1;
      grant_q    <= 2'b00;
      bus_en_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_meta_q <= busack_ni;
      ack_s_q    <= ack_meta_q;
      winner_q   <= winner_d;
      last_q     <= last_d;
      blocked_q  <= blocked_d;
      hold_q     <= hold_d;
      cool_q     <= cool_d;
      busrq_q    <= busrq_d;
      grant_q    <= grant_d;
      bus_en_q   <= bus_en_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busrq_no  = busrq_q;
  assign grant_o   = grant_q;
  assign bus_en_o  = bus_en_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_busreq_arbiter.sv
// Bench for busreq_arbiter: two instances (HOLD_MAX=16/CPU_MIN=8 and
// HOLD_MAX=7/CPU_MIN=0) share the same stimulus and are each compared every
// cycle against a tenure-level reference model, plus directed timing checks.
module tb_busreq_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       busack_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] busrq_w;
  logic [1:0] en_w;
  logic [1:0] to_w;
  logic [1:0] grant_w [2];

  always #5 clk = ~clk;

  busreq_arbiter #(.HOLD_MAX(16), .CPU_MIN(8)) u_dut_a (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .busack_ni(busack_n),
    .req_i    (req),
    .busrq_no (busrq_w[0]),
    .grant_o  (grant_w[0]),
    .bus_en_o (en_w[0]),
    .timeout_o(to_w[0])
  );

  busreq_arbiter #(.HOLD_MAX(7), .CPU_MIN(0)) u_dut_b (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .busack_ni(busack_n),
    .req_i    (req),
    .busrq_no (busrq_w[1]),
    .grant_o  (grant_w[1]),
    .bus_en_o (en_w[1]),
    .timeout_o(to_w[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: one tenure record per instance.
  int          hm [2] = '{16, 7};
  int          cm [2] = '{8, 0};
  bit          s1 [2], s2 [2];     // busack after one / two clk edges
  int          win [2];            // requester owning the tenure, -1 = none
  bit          gnt [2];            // tenure has been granted
  bit          rel [2];            // tenure is being handed back
  int          len [2];            // cycles spent granted
  int          idle_at [2];        // first edge at which a new request can be taken
  bit          lastg [2];
  logic [1:0]  blk [2];
  logic        e_busrq [2];
  logic [1:0]  e_grant [2];
  logic        e_en [2];
  logic        e_to [2];

  // Z80 bus model
  bit auto_ack = 0;
  bit rnd_ack = 0;
  int ack_dly = 1;
  int ack_cnt = 0;
  int t_ackfall = -1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      s1[k] = 1'b1; s2[k] = 1'b1;
      win[k] = -1; gnt[k] = 0; rel[k] = 0; len[k] = 0; idle_at[k] = 0;
      lastg[k] = 1'b1; blk[k] = 2'b00;
      e_busrq[k] = 1'b1; e_grant[k] = 2'b00; e_en[k] = 1'b0; e_to[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit         acks;
    bit         to;
    bit         busy;
    logic [1:0] elig;
    acks = s2[k];
    s2[k] = s1[k];
    s1[k] = busack_n;
    elig = req & ~blk[k];
    to = 0;
    if (win[k] < 0) begin
      if (cyc >= idle_at[k] && elig != 2'b00) begin
        if (elig == 2'b11) win[k] = lastg[k] ? 0 : 1;
        else win[k] = elig[1] ? 1 : 0;
        gnt[k] = 0;
        rel[k] = 0;
      end
    end else if (rel[k]) begin
      if (acks) begin
        idle_at[k] = cyc + cm[k] + 1;
        win[k] = -1;
      end
    end else if (!gnt[k]) begin
      if (!req[win[k]]) rel[k] = 1;
      else if (!acks) begin
        gnt[k] = 1;
        lastg[k] = (win[k] == 1);
        len[k] = 0;
      end
    end else begin
      len[k]++;
      if (!req[win[k]]) rel[k] = 1;
      else if (len[k] >= hm[k]) begin
        rel[k] = 1;
        to = 1;
      end else if (acks) rel[k] = 1;
    end
    blk[k] = blk[k] & req;
    if (to) blk[k][win[k]] = 1'b1;
    busy = (win[k] >= 0) && !rel[k];
    e_busrq[k] = !busy;
    e_en[k] = busy && gnt[k];
    e_grant[k] = (busy && gnt[k]) ? ((win[k] == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_to[k] = to;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busrq[%0d] cyc %0d", k, cyc), busrq_w[k], e_busrq[k]);
      chk($sformatf("grant[%0d] cyc %0d", k, cyc), grant_w[k], e_grant[k]);
      chk($sformatf("bus_en[%0d] cyc %0d", k, cyc), en_w[k], e_en[k]);
      chk($sformatf("timeout[%0d] cyc %0d", k, cyc), to_w[k], e_to[k]);
    end
    if (auto_ack) begin
      if (busrq_w[0] !== busack_n) begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin
          busack_n = busrq_w[0];
          if (!busack_n) t_ackfall = cyc;
          ack_cnt = 0;
          if (rnd_ack) ack_dly = $urandom_range(1, 4);
        end
      end else begin
        ack_cnt = 0;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asserts reset away from a clock edge, checks outputs before any edge,
  // and releases reset on the following falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busrq[%0d]", k), busrq_w[k], 1'b1);
      chk($sformatf("rst_grant[%0d]", k), grant_w[k], 2'b00);
      chk($sformatf("rst_bus_en[%0d]", k), en_w[k], 1'b0);
      chk($sformatf("rst_timeout[%0d]", k), to_w[k], 1'b0);
    end
    model_reset();
    req = 2'b00;
    busack_n = 1'b1;
    ack_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t_grant, ngr, held, rise, gaps, min_gap, glen, nto, ng, found, k, gd, bf;
    logic [1:0] seq [3];
    logic [1:0] cur, prev;
    logic pbr;

    model_reset();
    do_reset();

    // Single request: grant 3 clocks after BUSACK falls, then clean release.
    auto_ack = 1; rnd_ack = 0; ack_dly = 3;
    req = 2'b01;
    t_grant = -1;
    for (int i = 0; i < 20 && t_grant < 0; i++) begin
      tick();
      if (grant_w[0] === 2'b01) t_grant = cyc;
    end
    chk("single_grant_latency", t_grant - t_ackfall, 3);
    req = 2'b00;
    tick();
    chk("single_release_grant", grant_w[0], 2'b00);
    chk("single_release_busrq", busrq_w[0], 1'b1);
    ticks(20);

    // Simultaneous requests: round-robin 01,10,01 with CPU turnaround gap.
    do_reset();
    auto_ack = 1; ack_dly = 1;
    req = 2'b11;
    ngr = 0; held = 0; prev = 2'b00; pbr = 1'b1; rise = -1; gaps = 0; min_gap = 1000;
    for (int i = 0; i < 300 && ngr < 3; i++) begin
      tick();
      cur = grant_w[0];
      if (cur != 2'b00) begin
        if (prev == 2'b00) begin
          seq[ngr] = cur;
          ngr++;
          held = 0;
        end
        held++;
        if (held == 5) req = req & ~cur;
      end else begin
        req = 2'b11;
      end
      if (!pbr && busrq_w[0]) rise = cyc;
      if (pbr && !busrq_w[0] && rise >= 0) begin
        gaps++;
        if (cyc - rise < min_gap) min_gap = cyc - rise;
      end
      prev = cur;
      pbr = busrq_w[0];
    end
    chk("rr_grant_count", ngr, 3);
    chk("rr_first", seq[0], 2'b01);
    chk("rr_second", seq[1], 2'b10);
    chk("rr_third", seq[2], 2'b01);
    chk("rr_gap_count", gaps >= 2, 1);
    chk("rr_gap_min9", min_gap >= 9, 1);
    req = 2'b00;
    ticks(20);

    // Timeout: 16-cycle grant, one pulse, blocked until req drops.
    do_reset();
    auto_ack = 1; ack_dly = 1;
    req = 2'b01;
    glen = 0; nto = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (grant_w[0] === 2'b01) glen++;
      if (to_w[0] === 1'b1) nto++;
    end
    chk("timeout_grant_len", glen, 16);
    chk("timeout_pulses", nto, 1);
    chk("timeout_blocked_busrq", busrq_w[0], 1'b1);
    req = 2'b00;
    tick();
    req = 2'b01;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (grant_w[0] === 2'b01) found = 1;
    end
    chk("timeout_regrant", found, 1);
    req = 2'b00;
    ticks(30);

    // Abort in REQ: no grant, RELEASE then COOL before the next BUSRQ.
    do_reset();
    auto_ack = 0;
    busack_n = 1'b1;
    req = 2'b01;
    ticks(2);
    chk("abort_busrq_low", busrq_w[0], 1'b0);
    req = 2'b00;
    tick();
    chk("abort_busrq_high", busrq_w[0], 1'b1);
    rise = cyc;
    req = 2'b01;
    ng = 0; bf = -1;
    for (int i = 0; i < 40 && bf < 0; i++) begin
      tick();
      if (grant_w[0] !== 2'b00) ng++;
      if (busrq_w[0] === 1'b0) bf = cyc;
    end
    chk("abort_no_grant", ng, 0);
    chk("abort_turnaround", bf - rise, 10);
    req = 2'b00;
    ticks(15);

    // Reset in the middle of a tenure drops everything without a clock.
    do_reset();
    auto_ack = 1; ack_dly = 1;
    req = 2'b01;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (grant_w[0] === 2'b01) found = 1;
    end
    chk("midreset_granted", found, 1);
    ticks(2);
    do_reset();

    // BUSACK violation on the CPU_MIN=0 instance.
    auto_ack = 0;
    busack_n = 1'b1;
    req = 2'b01;
    tick();
    busack_n = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (grant_w[1] === 2'b01) found = 1;
    end
    chk("viol_granted", found, 1);
    k = cyc;
    busack_n = 1'b1;
    gd = -1; bf = -1; nto = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (gd < 0 && grant_w[1] === 2'b00) gd = cyc;
      if (gd >= 0 && bf < 0 && cyc > gd && busrq_w[1] === 1'b0) bf = cyc;
      if (to_w[1] === 1'b1) nto++;
      if (i == 4) busack_n = 1'b0;
    end
    chk("viol_grant_drop", gd - k, 3);
    chk("viol_rerequest", bf - k, 5);
    chk("viol_no_timeout", nto, 0);
    req = 2'b00;
    auto_ack = 1;
    ticks(20);

    // Random traffic with random BUSACK latency and occasional violations.
    do_reset();
    auto_ack = 1; rnd_ack = 1; ack_dly = 2;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (grant_w[0][i] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0))
            req[i] = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          req[i] = 1'b1;
        end
      end
      if (grant_w[0] != 2'b00 && $urandom_range(0, 99) == 0) busack_n = 1'b1;
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/busreq_arbiter.md
# busreq_arbiter

Bus-mastership controller for the Z80 system bus in front of the banked ROM/RAM behind the MMU. It arbitrates between two secondary bus masters, requester 0 and requester 1 (for example a disk DMA engine and a video fetch unit). It runs the Z80 BUSRQ/BUSACK handshake, grants the bus to one requester at a time and enforces a maximum hold time. After every tenure it guarantees the CPU a minimum number of clocks before the next grant. It sits beside the MMU, and its `bus_en` output gates the requester drivers onto address, data and `mreq`.

## Interface
Parameters:
- `HOLD_MAX`, 64: maximum grant length in clk cycles; legal range 1..255.
- `CPU_MIN`, 8: clk cycles the CPU keeps the bus after a tenure; legal range 0..255.

Ports:
- `clk`  input  1  system clock (undivided oscillator clock, same as the clock generator input).
- `reset`  input  1  asynchronous, active-low reset.
- `busack`  input  1  active-low BUSACK from the Z80; asynchronous to `clk` (CPU runs on the divided `sysclk`).
- `req`  input  2  active-high bus requests; bit 0 is requester 0, bit 1 is requester 1.
- `busrq`  output  1  active-low BUSRQ to the Z80.
- `grant`  output  2  one-hot active-high grant; at most one bit set.
- `bus_en`  output  1  active-high enable for the granted requester's drivers.
- `timeout`  output  1  one-cycle pulse when a tenure is cut off at `HOLD_MAX`.

## Operation
- Input synchronisation: `busack` passes through a 2-flop synchroniser to produce `busack_s`. `req` is sampled directly; requesters are synchronous to `clk`.
- FSM states and behaviour:
  - IDLE: `busrq`=1.
    - If any unblocked `req` bit is high, choose a winner and go to REQ.
    - With both bits eligible, round-robin: the winner is the requester that was not last granted.
    - `last` resets to 1, so requester 0 wins the first contest.
  - REQ: `busrq`=0.
    - `busack_s`==0 goes to GRANT; set `grant[winner]` and `bus_en`, record `last`=winner, and clear the hold counter.
    - The winner dropping `req` before the grant goes to RELEASE (abort).
  - GRANT: `busrq`=0, `grant`/`bus_en` asserted.
    - The hold counter increments each cycle.
    - The winner dropping `req` goes to RELEASE.
    - Counter reaching `HOLD_MAX` while `req` is still high goes to RELEASE, pulses `timeout`, and sets `blocked[winner]`.
    - `busack_s` rising goes to RELEASE without `timeout`; this is a protocol violation and the block must not hang.
  - RELEASE: `busrq`=1, `grant`=0, `bus_en`=0.
    - Wait for `busack_s`==1, then load the cool counter with `CPU_MIN` and go to COOL.
    - If `CPU_MIN`==0, go directly to IDLE.
  - COOL: `busrq`=1. Decrement the cool counter; on reaching 0, go to IDLE.
- `blocked[i]` clears on any cycle where `req[i]`==0. A blocked requester is ineligible in IDLE.
- A request from the non-winner during any tenure is held off. It is served on the next IDLE pass.
- Counters:
  - The hold counter is 8 bits and saturates; it never wraps.
  - The cool counter is 8 bits.
- Outputs are registered and glitch-free.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `busrq`=1, `grant`=00, `bus_en`=0, `timeout`=0, `last`=1, `blocked`=00, counters=0, synchroniser flops=1.
- Reset asserted mid-tenure releases the bus in zero clocks. Deassertion is taken on a `clk` edge.
- Request latency:
  - `req` high before edge N gives `busrq` low after edge N.
  - `busack` low before edge M gives `busack_s` low after edge M+1.
  - `grant` and `bus_en` go high after edge M+2.
- Grant length:
  - With `req` held, `grant` is high for exactly `HOLD_MAX` cycles.
  - `timeout` is high for 1 cycle, coincident with the first RELEASE cycle.
- Release: `req` low before edge R drops `grant`, `bus_en` and `busrq` (high) together after edge R.
- Turnaround:
  - `busack` high before edge P gives COOL entry after edge P+2.
  - The next `busrq` assertion occurs no earlier than `CPU_MIN`+1 cycles after COOL entry.

## Test plan
- Reset, single request:
  - Stimulus: `req`=01; the bus model drives `busack` low 3 cycles after `busrq` falls.
  - Required response: `grant`=01 and `bus_en`=1 exactly 3 clk after `busack` falls.
  - Then drop `req`: `grant`=00 and `busrq`=1 on the next edge.
- Simultaneous requests:
  - Stimulus: `req`=11 from reset; each requester releases after 5 cycles, with `CPU_MIN`=8.
  - Required response: grants alternate 01,10,01. At least 9 clk separate each `busrq` rise from the next fall.
- Timeout:
  - Stimulus: `HOLD_MAX`=16, `req`=01 held high.
  - Required response: `grant` high for exactly 16 cycles, and `timeout` pulses once.
  - Requester 0 is not re-granted while `req[0]` stays high. After `req[0]` drops for 1 cycle and rises again, it is re-granted.
- Abort:
  - Stimulus: `req`=01 drops while in REQ, before `busack` falls.
  - Required response: `grant` is never asserted, `busrq` returns high, and the FSM passes through RELEASE and COOL to IDLE after `busack` rises.
- Reset mid-tenure:
  - Stimulus: assert `reset` low during GRANT.
  - Required response: `grant`=00, `bus_en`=0 and `busrq`=1 within the same cycle, without waiting for a clock.
- Protocol violation and zero cool time:
  - Stimulus: `busack` pulses high for 4 clk during GRANT, with `CPU_MIN`=0.
  - Required response: `grant` drops with no `timeout`. IDLE is reached 2 clk after `busack_s` high, and a pending `req` re-asserts `busrq` on the following edge.
